// File: rtl/icnd2110_pkg.sv
// Shared types and constants for the ICND2110 write-side frame controller.
package icnd2110_pkg;

   localparam int WORD_COUNT_DEF = 336;
   localparam int ADDR_W_DEF     = 12;

   localparam logic [1:0] FILL_SOLID = 2'd0;
   localparam logic [1:0] FILL_RAMP  = 2'd1;
   localparam logic [1:0] FILL_WALK  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FILL    = 2'd1,
      ST_PENDING = 2'd2
   } state_t;

   // Who won the most recent write-port contest.
   typedef enum logic {
      GR_HOST = 1'b0,
      GR_FILL = 1'b1
   } grant_t;

endpackage

// File: rtl/icnd2110_frame_ctrl_if.sv
// Host pixel-write bus into the frame controller.
// Handshake: a word transfers on every cycle where host_valid && host_ready;
// host_ready never depends on host_valid, and the host holds data/addr while valid.
interface icnd2110_frame_ctrl_if #(
   parameter int ADDR_W = icnd2110_pkg::ADDR_W_DEF
);
   logic [15:0]       host_data;
   logic [ADDR_W-1:0] host_addr;
   logic              host_valid;
   logic              host_ready;

   modport master (output host_data, output host_addr, output host_valid, input host_ready);
   modport slave  (input host_data, input host_addr, input host_valid, output host_ready);
endinterface

// File: rtl/icnd2110_pattern_gen.sv
// Combinational test-pattern word for a given fill mode, word index and fill value.
module icnd2110_pattern_gen
   import icnd2110_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] idx,
   input  logic [15:0]       value,
   output logic [15:0]       word
);

   logic [11:0] idx12;
   assign idx12 = 12'(idx);

   always_comb begin
      word = value;
      case (mode)
         FILL_RAMP: word = {idx12, 4'h0};
         FILL_WALK: word = (idx == value[ADDR_W-1:0]) ? 16'hFFFF : 16'h0000;
         default:   word = value;   // mode 3 falls back to solid
      endcase
   end

endmodule

// File: rtl/icnd2110_frame_ctrl.sv
// ICND2110 write-side controller: host/fill round-robin on the pixel write port
// and double-buffer bank swap at output-engine frame boundaries.
module icnd2110_frame_ctrl
   import icnd2110_pkg::*;
#(
   parameter int WORD_COUNT = WORD_COUNT_DEF,
   parameter int ADDR_W     = ADDR_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   icnd2110_frame_ctrl_if.slave host,
   input  logic                host_commit,
   input  logic                fill_start,
   input  logic [1:0]          fill_mode,
   input  logic [15:0]         fill_value,
   input  logic                frame_done,
   output logic                mem_wr_en,
   output logic [ADDR_W:0]     mem_wr_addr,
   output logic [15:0]         mem_wr_data,
   output logic                rd_bank,
   output logic                swap_done,
   output logic                busy,
   output logic                err_addr,
   output state_t              dbg_state
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORD_COUNT - 1);

   state_t            state, state_nx;
   grant_t            last_grant;
   logic [ADDR_W-1:0] fill_idx;
   logic [1:0]        mode_q;
   logic [15:0]       value_q;
   logic [15:0]       pat_word;
   logic [ADDR_W-1:0] h_addr;
   logic              fill_req, host_rdy, host_acc, fill_gnt, host_in_range, do_swap;

   assign h_addr        = host.host_addr;
   assign host_in_range = (h_addr <= LAST_IDX);
   assign fill_req      = (state == ST_FILL);

   // The fill engine only blocks the host when the host won the previous contest.
   assign host_rdy = !rst && (state != ST_PENDING) && !(fill_req && last_grant == GR_HOST);
   assign host_acc = host.host_valid && host_rdy;
   assign fill_gnt = fill_req && !host_acc;

   assign host.host_ready = host_rdy;
   assign busy            = (state != ST_IDLE);
   assign dbg_state       = state;

   icnd2110_pattern_gen #(.ADDR_W(ADDR_W)) u_pattern (
      .mode  (mode_q),
      .idx   (fill_idx),
      .value (value_q),
      .word  (pat_word)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      do_swap  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (fill_start)       state_nx = ST_FILL;
            else if (host_commit) state_nx = ST_PENDING;
         end
         ST_FILL: begin
            if (fill_gnt && fill_idx == LAST_IDX) state_nx = ST_PENDING;
         end
         ST_PENDING: begin
            if (frame_done) begin
               state_nx = ST_IDLE;
               do_swap  = 1'b1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // The back-bank bit is captured with the grant, so a write registered on
   // the way into PENDING still lands in the bank that was back at that time.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant  <= GR_FILL;
         fill_idx    <= '0;
         mode_q      <= FILL_SOLID;
         value_q     <= '0;
         mem_wr_en   <= 1'b0;
         mem_wr_addr <= '0;
         mem_wr_data <= '0;
         rd_bank     <= 1'b0;
         swap_done   <= 1'b0;
         err_addr    <= 1'b0;
      end else begin
         mem_wr_en <= 1'b0;
         swap_done <= 1'b0;
         if (host_acc) begin
            last_grant <= GR_HOST;
            if (host_in_range) begin
               mem_wr_en   <= 1'b1;
               mem_wr_addr <= {~rd_bank, h_addr};
               mem_wr_data <= host.host_data;
            end else begin
               err_addr <= 1'b1;
            end
         end else if (fill_gnt) begin
            last_grant  <= GR_FILL;
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= {~rd_bank, fill_idx};
            mem_wr_data <= pat_word;
            fill_idx    <= fill_idx + 1'b1;
         end
         if (state == ST_IDLE && fill_start) begin
            fill_idx <= '0;
            mode_q   <= fill_mode;
            value_q  <= fill_value;
         end
         if (do_swap) begin
            rd_bank   <= ~rd_bank;
            swap_done <= 1'b1;
         end
      end
   end

endmodule

// File: doc/icnd2110_frame_ctrl.md
# icnd2110_frame_ctrl

Write-side controller for the ICND2110 LED output path. It shares the 16-bit pixel-memory write port between the SPI host and a built-in test-pattern fill engine using round-robin arbitration. It owns the double-buffer bank select and swaps front and back banks only at frame boundaries reported by the ICND2110 output engine.

## Interface
- WORD_COUNT, 336: pixel words per bank.
- ADDR_W, 12: word address width; must satisfy 2^ADDR_W ≥ WORD_COUNT.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- host_data  in  16  host write data.
- host_addr  in  ADDR_W  host word address within the back bank.
- host_valid  in  1  host write request.
- host_ready  out  1  host write accepted when host_valid && host_ready.
- host_commit  in  1  one-cycle pulse: request back/front swap.
- fill_start  in  1  one-cycle pulse: start a pattern fill of the back bank.
- fill_mode  in  2  0 solid, 1 ramp, 2 walking; 3 treated as solid.
- fill_value  in  16  solid colour (mode 0), or lit index (mode 2).
- frame_done  in  1  one-cycle pulse from the output engine at end of frame.
- mem_wr_en  out  1  pixel-memory write strobe.
- mem_wr_addr  out  ADDR_W+1  {back_bank, word address}.
- mem_wr_data  out  16  write data.
- rd_bank  out  1  bank the output engine reads (front).
- swap_done  out  1  one-cycle pulse when rd_bank toggles.
- busy  out  1  high in FILL or PENDING.
- err_addr  out  1  sticky; set on any accepted host write with host_addr ≥ WORD_COUNT.

## Operation
- States: IDLE, FILL, PENDING. Back bank = !rd_bank.
- IDLE:
  - fill_start → FILL, fill_idx=0, fill_mode and fill_value latched.
  - host_commit → PENDING.
  - Simultaneous fill_start and host_commit: fill_start wins; commit dropped.
- FILL:
  - Fill engine requests every cycle until fill_idx = WORD_COUNT-1 has been granted, then → PENDING (auto-commit).
  - host_commit and fill_start are ignored in FILL.
- PENDING:
  - No writes are granted: host_ready=0, fill idle.
  - frame_done → rd_bank toggles, swap_done pulses, → IDLE.
  - host_commit and fill_start are ignored.
- Arbitration:
  - Round-robin on a last_grant register; reset value FILL, so the host wins the first contest.
  - host_ready = (state≠PENDING) && !(fill requesting && last_grant==HOST). It does not depend on host_valid.
  - A fill request is granted when the host is not granted.
- Pattern data:
  - Solid: fill_value.
  - Ramp: {fill_idx[11:0], 4'h0}, with fill_idx zero-extended/truncated to 12 bits.
  - Walking: 16'hFFFF when fill_idx == fill_value[ADDR_W-1:0], else 0.
- Out-of-range host write: accepted, no mem_wr_en, err_addr set. err_addr clears only on rst.

## Timing
- Request handshake in cycle N (host accept, or fill grant) → mem_wr_en, mem_wr_addr and mem_wr_data registered in N+1. One write per cycle maximum.
- Fill throughput:
  - Alone: WORD_COUNT cycles.
  - With a continuous host stream: 1 word per 2 cycles.
  - FILL→PENDING transition occurs in the cycle after the last fill grant.
- Swap latency:
  - frame_done in cycle N while PENDING → rd_bank and swap_done in N+1.
  - frame_done in the same cycle as the PENDING entry condition (commit or last fill grant) does not swap; the next frame_done does.
- A write already registered when PENDING is entered still completes to the old back bank, because the bank bit is sampled at grant.
- Reset values: host_ready 0 during rst, mem_wr_en 0, mem_wr_addr 0, mem_wr_data 0, rd_bank 0, swap_done 0, busy 0, err_addr 0, state IDLE, last_grant FILL.
- Reset mid-fill or mid-PENDING abandons the operation; no swap occurs.

## Structure
- Shared package icnd2110_pkg:
  - State enum (IDLE/FILL/PENDING).
  - Fill-mode constants FILL_SOLID=0, FILL_RAMP=1, FILL_WALK=2.
  - WORD_COUNT default.
- One natural sub-module: icnd2110_pattern_gen (combinational mode/index/value → 16-bit word). The FSM and arbiter stay in the top.

## Test plan
- Host writes addr 5 = 16'h1234, then host_commit, then frame_done → mem write {1,5}=1234 one cycle after accept; rd_bank=1 and swap_done one cycle after frame_done.
- fill_start mode 1 with host idle → 336 consecutive writes, word 3 = 16'h0030, busy high throughout; PENDING after the last write; no swap until frame_done.
- Fill mode 0, value 16'hABCD, with host_valid held high → grants alternate host/fill starting with host; fill completes in 672 cycles.
- host_commit and frame_done in the same cycle from IDLE → no swap that cycle; swap on the next frame_done. host_ready=0 throughout PENDING.
- Host write at addr 400 → host_ready handshake completes, no mem_wr_en, err_addr=1 and stays set until rst.
- rst asserted at fill word 100 → all outputs at reset values next cycle, rd_bank=0, a subsequent frame_done produces no swap.
